// File: rtl/mem_port_arbiter.sv
// Merges the core's instruction and data request ports onto one memory port with
// round-robin arbitration, and routes in-order responses back via a tag FIFO.
module mem_port_arbiter #(
  parameter int C_OTX_DEPTH_X = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqsize_i,
  input  logic        dreqwrite_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o,
  input  logic        mreqready_i,
  output logic        mreqvalid_o,
  output logic [1:0]  mreqsize_o,
  output logic        mreqwrite_o,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic [31:0] mreqdata_o,
  output logic        mrspready_o,
  input  logic        mrspvalid_i,
  input  logic        mrsperr_i,
  input  logic [31:0] mrspdata_i
);
  localparam int DEPTH = 1 << C_OTX_DEPTH_X;
  localparam int PW    = C_OTX_DEPTH_X;

  typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

  logic [PW:0]      cnt_q, cnt_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH-1:0] tsrc_q, tsrc_d, twr_q, twr_d;
  src_e             last_q, last_d, lsrc_q, lsrc_d;
  logic             lock_q, lock_d;

  src_e gnt, head_src;
  logic active, full, empty, gvld, accept, pop, head_wr, rsp_en;

  always_comb begin
    active = clk_en_i & ~reset_i;
    full   = (cnt_q == (PW+1)'(DEPTH));
    empty  = (cnt_q == '0);

    // A stalled request keeps its grant until memory takes it.
    if (lock_q)                         gnt = lsrc_q;
    else if (ireqvalid_i & ~dreqvalid_i) gnt = SRC_I;
    else if (dreqvalid_i & ~ireqvalid_i) gnt = SRC_D;
    else                                 gnt = (last_q == SRC_D) ? SRC_I : SRC_D;

    gvld        = (gnt == SRC_D) ? dreqvalid_i : ireqvalid_i;
    mreqvalid_o = active & ~full & gvld;
    ireqready_o = active & ~full & (gnt == SRC_I) & mreqready_i;
    dreqready_o = active & ~full & (gnt == SRC_D) & mreqready_i;
    mreqsize_o  = (gnt == SRC_D) ? dreqsize_i : 2'b10;
    mreqwrite_o = (gnt == SRC_D) & dreqwrite_i;
    mreqhpl_o   = (gnt == SRC_D) ? dreqhpl_i : ireqhpl_i;
    mreqaddr_o  = (gnt == SRC_D) ? dreqaddr_i : ireqaddr_i;
    mreqdata_o  = (gnt == SRC_D) ? dreqdata_i : 32'h0;
    accept      = mreqvalid_o & mreqready_i;

    head_src    = src_e'(tsrc_q[rptr_q]);
    head_wr     = twr_q[rptr_q];
    rsp_en      = active & ~empty;
    irspvalid_o = rsp_en & (head_src == SRC_I) & mrspvalid_i;
    drspvalid_o = rsp_en & (head_src == SRC_D) & mrspvalid_i;
    irsprerr_o  = rsp_en & (head_src == SRC_I) & mrsperr_i;
    drsprerr_o  = rsp_en & (head_src == SRC_D) & mrsperr_i & ~head_wr;
    drspwerr_o  = rsp_en & (head_src == SRC_D) & mrsperr_i & head_wr;
    irspdata_o  = mrspdata_i;
    drspdata_o  = mrspdata_i;
    mrspready_o = rsp_en & ((head_src == SRC_D) ? drspready_i : irspready_i);
    pop         = mrspvalid_i & mrspready_o;

    last_d = last_q;
    lock_d = lock_q;
    lsrc_d = lsrc_q;
    tsrc_d = tsrc_q;
    twr_d  = twr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;

    if (accept) begin
      last_d         = gnt;
      lock_d         = 1'b0;
      tsrc_d[wptr_q] = gnt;
      twr_d[wptr_q]  = mreqwrite_o;
      wptr_d         = wptr_q + 1'b1;
    end else if (mreqvalid_o) begin
      lock_d = 1'b1;
      lsrc_d = gnt;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      tsrc_q <= '0;
      twr_q  <= '0;
      last_q <= SRC_D;
      lsrc_q <= SRC_I;
      lock_q <= 1'b0;
    end else if (clk_en_i) begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      tsrc_q <= tsrc_d;
      twr_q  <= twr_d;
      last_q <= last_d;
      lsrc_q <= lsrc_d;
      lock_q <= lock_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: drivers act as core and memory; a scoreboard of outstanding
// tags predicts grant choice, full/stall behaviour and response routing.
module tb_mem_port_arbiter;
  logic        clk_i = 1'b0, reset_i = 1'b1, clk_en_i = 1'b1;
  logic        ireqready_o, ireqvalid_i = 0, irspready_i = 0, irspvalid_o, irsprerr_o;
  logic [1:0]  ireqhpl_i = 0;
  logic [31:0] ireqaddr_i = 0, irspdata_o;
  logic        dreqready_o, dreqvalid_i = 0, dreqwrite_i = 0, drspready_i = 0;
  logic        drspvalid_o, drsprerr_o, drspwerr_o;
  logic [1:0]  dreqsize_i = 0, dreqhpl_i = 0;
  logic [31:0] dreqaddr_i = 0, dreqdata_i = 0, drspdata_o;
  logic        mreqready_i = 0, mreqvalid_o, mreqwrite_o, mrspready_o;
  logic        mrspvalid_i = 0, mrsperr_i = 0;
  logic [1:0]  mreqsize_o, mreqhpl_o;
  logic [31:0] mreqaddr_o, mreqdata_o, mrspdata_i = 0;

  mem_port_arbiter #(.C_OTX_DEPTH_X(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i),
    .dreqwrite_i(dreqwrite_i), .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i),
    .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
    .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqsize_o(mreqsize_o),
    .mreqwrite_o(mreqwrite_o), .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o),
    .mreqdata_o(mreqdata_o), .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i),
    .mrsperr_i(mrsperr_i), .mrspdata_i(mrspdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic src; logic wr; } tag_t;  // src: 0 = I, 1 = D
  tag_t mq[$];
  int   vec = 0, errs = 0;
  bit   run = 0, last = 1'b1, held_v = 0, held_s = 0, i_acc = 0, d_acc = 0;
  int   ngrant_i = 0, ngrant_d = 0, nfull = 0;

  function automatic void chk1(string name, logic act, logic exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: the memory port sees requests in grant order, at most four
  // unanswered, and each response belongs to the oldest unanswered request.
  always @(negedge clk_i) begin : monitor
    bit s, full, emv, eiv, edv, erdy;
    tag_t h;
    if (run && !reset_i) begin
      full = (mq.size() >= 4);
      if (held_v)                          s = held_s;
      else if (ireqvalid_i && !dreqvalid_i) s = 1'b0;
      else if (dreqvalid_i && !ireqvalid_i) s = 1'b1;
      else                                  s = !last;
      emv = clk_en_i && !full && (s ? dreqvalid_i : ireqvalid_i);
      if (full && clk_en_i) nfull++;
      chk1("mreqvalid", mreqvalid_o, emv);
      chk1("ireqready", ireqready_o, clk_en_i && !full && !s && mreqready_i);
      chk1("dreqready", dreqready_o, clk_en_i && !full && s && mreqready_i);
      if (emv) begin
        chk32("mreqaddr", mreqaddr_o, s ? dreqaddr_i : ireqaddr_i);
        chk32("mreqsize", 32'(mreqsize_o), 32'(s ? dreqsize_i : 2'b10));
        chk1("mreqwrite", mreqwrite_o, s ? dreqwrite_i : 1'b0);
        chk32("mreqhpl", 32'(mreqhpl_o), 32'(s ? dreqhpl_i : ireqhpl_i));
        chk32("mreqdata", mreqdata_o, s ? dreqdata_i : 32'h0);
      end
      eiv = 0; edv = 0; erdy = 0; h = '0;
      if (clk_en_i && mq.size() > 0) begin
        h    = mq[0];
        eiv  = mrspvalid_i && !h.src;
        edv  = mrspvalid_i && h.src;
        erdy = h.src ? drspready_i : irspready_i;
      end
      chk1("irspvalid", irspvalid_o, eiv);
      chk1("drspvalid", drspvalid_o, edv);
      chk1("mrspready", mrspready_o, erdy);
      if (eiv) begin
        chk32("irspdata", irspdata_o, mrspdata_i);
        chk1("irsprerr", irsprerr_o, mrsperr_i);
      end
      if (edv) begin
        chk32("drspdata", drspdata_o, mrspdata_i);
        chk1("drsprerr", drsprerr_o, mrsperr_i && !h.wr);
        chk1("drspwerr", drspwerr_o, mrsperr_i && h.wr);
      end
      if (mrspvalid_i && erdy) void'(mq.pop_front());
      i_acc = emv && mreqready_i && !s;
      d_acc = emv && mreqready_i && s;
      if (emv && mreqready_i) begin
        mq.push_back(tag_t'{src: s, wr: s ? dreqwrite_i : 1'b0});
        last = s; held_v = 0;
        if (s) ngrant_d++; else ngrant_i++;
      end else if (emv) begin
        held_v = 1; held_s = s;
      end
    end
  end

  task automatic reset_check(string tagname);
    chk1({tagname, " mreqvalid"}, mreqvalid_o, 1'b0);
    chk1({tagname, " ireqready"}, ireqready_o, 1'b0);
    chk1({tagname, " dreqready"}, dreqready_o, 1'b0);
    chk1({tagname, " irspvalid"}, irspvalid_o, 1'b0);
    chk1({tagname, " drspvalid"}, drspvalid_o, 1'b0);
    chk1({tagname, " mrspready"}, mrspready_o, 1'b0);
  endtask

  initial begin
    int pm, pr;
    ireqvalid_i = 1; dreqvalid_i = 1; mrspvalid_i = 1; mreqready_i = 1;
    irspready_i = 1; drspready_i = 1;
    repeat (3) @(posedge clk_i);
    #1 reset_check("reset");
    ireqvalid_i = 0; dreqvalid_i = 0; mrspvalid_i = 0;
    reset_i = 0;
    run = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_i); #1;
      if (cyc == 2000) begin
        ireqvalid_i = 1; mrspvalid_i = 1; irspready_i = 1; drspready_i = 1;
        reset_i = 1;
        #1 reset_check("midreset");
        mq.delete(); held_v = 0; last = 1'b1; i_acc = 0; d_acc = 0;
        @(posedge clk_i); #1 reset_i = 0;
      end
      // Phases alternate slow / medium / fast responses so the FIFO fills and drains.
      case ((cyc / 150) % 3)
        0:       begin pm = 8; pr = 1; end
        1:       begin pm = 3; pr = 4; end
        default: begin pm = 6; pr = 7; end
      endcase
      if (!ireqvalid_i || i_acc) begin
        ireqvalid_i = ($urandom_range(0, 3) != 0);
        ireqaddr_i  = $urandom;
        ireqhpl_i   = 2'($urandom);
      end
      if (!dreqvalid_i || d_acc) begin
        dreqvalid_i = ($urandom_range(0, 3) != 0);
        dreqaddr_i  = $urandom;
        dreqdata_i  = $urandom;
        dreqsize_i  = 2'($urandom);
        dreqwrite_i = 1'($urandom);
        dreqhpl_i   = 2'($urandom);
      end
      clk_en_i    = ($urandom_range(0, 9) != 0);
      mreqready_i = ($urandom_range(0, 9) < pm);
      mrspvalid_i = ($urandom_range(0, 7) < pr);
      mrspdata_i  = $urandom;
      mrsperr_i   = ($urandom_range(0, 3) == 0);
      irspready_i = ($urandom_range(0, 3) != 0);
      drspready_i = ($urandom_range(0, 3) != 0);
    end
    run = 0;
    vec++;
    if (ngrant_i == 0 || ngrant_d == 0 || nfull == 0) begin
      errs++;
      $display("FAIL coverage: grants I=%0d D=%0d full cycles=%0d, each required nonzero",
               ngrant_i, ngrant_d, nfull);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
